// File: rtl/mac_seq_ctrl.sv
// Control sequencer for the MAC datapath: clears ACC, walks operand memories for len terms,
// strobes ACC loads as products arrive, drains the product pipeline, then pulses done.
module mac_seq_ctrl #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [PIPE_LAT-1:0] pipe_q, pipe_d;
   logic                last_term;

   assign last_term = ({1'b0, cnt_q} == (len_q - (ADDR_W + 1)'(1)));

   // Valid pipeline tracks issued reads so acc_en lines up with each product.
   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = (state_q == StRun);
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (abort) begin
         pipe_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d = StClear;
               len_d   = len;
               cnt_d   = '0;
            end
         end
         StClear: begin
            state_d = (len_q == '0) ? StDone : StRun;
         end
         StRun: begin
            // Hold the counter on the last term so a full-length run never wraps.
            if (last_term) begin
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (pipe_d == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         pipe_q  <= pipe_d;
      end
   end

   assign rd_en   = (state_q == StRun);
   assign addr    = cnt_q;
   assign acc_clr = (state_q == StClear);
   assign acc_en  = pipe_q[PIPE_LAT-1];
   assign busy    = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
   assign done    = (state_q == StDone);

endmodule
